// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from video_timing_gen (master) to the sprite compositor (slave).
// The test-pattern colour lanes exist only when VTG_TEST_PATTERN_EN is defined.
interface video_timing_gen_if;
  logic [15:0] o_x;
  logic [15:0] o_y;
  logic        o_h_sync;
  logic        o_v_sync;
  logic        o_de;
  logic        o_frame_start;
  logic [15:0] o_frame_cnt;
`ifdef VTG_TEST_PATTERN_EN
  logic [7:0]  o_tp_red;
  logic [7:0]  o_tp_green;
  logic [7:0]  o_tp_blue;

  modport master (
    output o_x, o_y, o_h_sync, o_v_sync, o_de, o_frame_start, o_frame_cnt,
    output o_tp_red, o_tp_green, o_tp_blue
  );
  modport slave (
    input o_x, o_y, o_h_sync, o_v_sync, o_de, o_frame_start, o_frame_cnt,
    input o_tp_red, o_tp_green, o_tp_blue
  );
`else
  modport master (
    output o_x, o_y, o_h_sync, o_v_sync, o_de, o_frame_start, o_frame_cnt
  );
  modport slave (
    input o_x, o_y, o_h_sync, o_v_sync, o_de, o_frame_start, o_frame_cnt
  );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// 800x600@60 raster timing generator: coordinates, syncs, data-enable, frame pulse/counter.
// Define VTG_TEST_PATTERN_EN to add the registered 8-bar colour test pattern.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          H_POL    = 1'b1,
  parameter bit          V_POL    = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  video_timing_gen_if.master o_vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT      = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT      = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END     = 16'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] r_frame_cnt;
  logic        r_h_sync;
  logic        r_v_sync;
  logic        r_de;
  logic        r_frame_start;

  state_t      w_next_state;
  logic [15:0] w_next_x;
  logic [15:0] w_next_y;
  logic [15:0] w_next_frame_cnt;
  logic        w_next_frame_start;
  logic        w_next_run;
  logic        w_next_de;
  logic        w_next_h_sync;
  logic        w_next_v_sync;

  // Next raster position; the first tick after reset presents (0,0) as a new frame.
  always_comb begin
    w_next_state       = r_state;
    w_next_x           = r_x;
    w_next_y           = r_y;
    w_next_frame_cnt   = r_frame_cnt;
    w_next_frame_start = 1'b0;
    if (i_en) begin
      case (r_state)
        ST_IDLE: begin
          w_next_state       = ST_RUN;
          w_next_x           = 16'd0;
          w_next_y           = 16'd0;
          w_next_frame_start = 1'b1;
        end
        ST_RUN: begin
          if (r_x < H_LAST) begin
            w_next_x = r_x + 16'd1;
          end else begin
            w_next_x = 16'd0;
            if (r_y < V_LAST) begin
              w_next_y = r_y + 16'd1;
            end else begin
              w_next_y           = 16'd0;
              w_next_frame_cnt   = r_frame_cnt + 16'd1;
              w_next_frame_start = 1'b1;
            end
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Decoding from the next position keeps syncs/de aligned with the registered coordinates.
  always_comb begin
    w_next_run    = (w_next_state == ST_RUN);
    w_next_de     = w_next_run && (w_next_x < H_ACT) && (w_next_y < V_ACT);
    w_next_h_sync = (w_next_run && (w_next_x >= HS_START) && (w_next_x < HS_END))
                    ? H_POL : ~H_POL;
    w_next_v_sync = (w_next_run && (w_next_y >= VS_START) && (w_next_y < VS_END))
                    ? V_POL : ~V_POL;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_x           <= 16'd0;
      r_y           <= 16'd0;
      r_frame_cnt   <= 16'd0;
      r_h_sync      <= ~H_POL;
      r_v_sync      <= ~V_POL;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_x           <= w_next_x;
      r_y           <= w_next_y;
      r_frame_cnt   <= w_next_frame_cnt;
      r_h_sync      <= w_next_h_sync;
      r_v_sync      <= w_next_v_sync;
      r_de          <= w_next_de;
      r_frame_start <= w_next_frame_start;
    end
  end

  assign o_vid.o_x           = r_x;
  assign o_vid.o_y           = r_y;
  assign o_vid.o_frame_cnt   = r_frame_cnt;
  assign o_vid.o_h_sync      = r_h_sync;
  assign o_vid.o_v_sync      = r_v_sync;
  assign o_vid.o_de          = r_de;
  assign o_vid.o_frame_start = r_frame_start;

`ifdef VTG_TEST_PATTERN_EN
  localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

  logic [15:0] w_bar;
  logic [2:0]  w_bar_idx;
  logic [23:0] w_next_rgb;
  logic [23:0] r_rgb;

  // Bar index is clamped so any H_ACTIVE not divisible by 8 still ends on black.
  always_comb begin
    w_bar      = w_next_x / BAR_W;
    w_bar_idx  = (w_bar > 16'd7) ? 3'd7 : w_bar[2:0];
    w_next_rgb = 24'h000000;
    if (w_next_de) begin
      case (w_bar_idx)
        3'd0:    w_next_rgb = 24'hFFFFFF;
        3'd1:    w_next_rgb = 24'hFFFF00;
        3'd2:    w_next_rgb = 24'h00FFFF;
        3'd3:    w_next_rgb = 24'h00FF00;
        3'd4:    w_next_rgb = 24'hFF00FF;
        3'd5:    w_next_rgb = 24'hFF0000;
        3'd6:    w_next_rgb = 24'h0000FF;
        default: w_next_rgb = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb <= 24'h000000;
    end else begin
      r_rgb <= w_next_rgb;
    end
  end

  assign o_vid.o_tp_red   = r_rgb[23:16];
  assign o_vid.o_tp_green = r_rgb[15:8];
  assign o_vid.o_tp_blue  = r_rgb[7:0];
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster coordinates, sync pulses and data-enable for the 800x600@60 display path.
- Directly upstream of the sprite compositor: o_x, o_y and o_v_sync drive the compositor's i_x, i_y and i_v_sync.
- The compositor advances sprite position on each rising edge of o_v_sync, so exactly one such edge per frame is required.
- Runs from the system clock; i_en is the pixel tick, which lets the block run from a clock faster than the pixel rate.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
H_POL, 1, active level of o_h_sync
V_POL, 1, active level of o_v_sync

Ports:
i_clk  input  1  system clock, all state on rising edge
i_rst_n  input  1  reset, asynchronous assert, active-low
i_en  input  1  pixel tick; raster advances one pixel per clock with i_en=1
o_x  output  16  horizontal count, 0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1056)
o_y  output  16  vertical count, 0..V_TOTAL-1, V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (628)
o_h_sync  output  1  horizontal sync
o_v_sync  output  1  vertical sync
o_de  output  1  active video: o_x<H_ACTIVE and o_y<V_ACTIVE
o_frame_start  output  1  single-clock pulse when pixel (0,0) is presented
o_frame_cnt  output  16  completed-frame counter, wraps modulo 2^16

Behaviour:
- All outputs are registered. All outputs are mutually aligned and describe the same pixel (o_x,o_y) in the same clock.
- Reset values (while i_rst_n=0, asynchronous):
  - o_x=0, o_y=0, o_de=0, o_frame_start=0, o_frame_cnt=0.
  - o_h_sync=~H_POL, o_v_sync=~V_POL.
  - Internal running flag = 0.
- States:
  - IDLE (after reset): outputs hold their reset values until the first clock with i_en=1.
  - On that clock, go to RUN and present pixel (0,0): o_de=1, o_frame_start=1, syncs inactive, o_frame_cnt stays 0.
- RUN, each clock with i_en=1:
  - If o_x<H_TOTAL-1: o_x+1.
  - Otherwise o_x=0 and:
    - if o_y<V_TOTAL-1, o_y+1;
    - else o_y=0, o_frame_cnt+1 and o_frame_start=1.
- Counter arithmetic is 16-bit unsigned. The counters never exceed TOTAL-1.
- o_h_sync = H_POL when H_ACTIVE+H_FP <= o_x < H_ACTIVE+H_FP+H_SYNC (840..967 at defaults), else ~H_POL.
- o_v_sync = V_POL when V_ACTIVE+V_FP <= o_y < V_ACTIVE+V_FP+V_SYNC (601..604), else ~V_POL.
  - Asserts and deasserts with o_x=0, giving whole lines.
  - Exactly one active edge per frame.
- i_en=0:
  - o_x, o_y, syncs, o_de and o_frame_cnt hold.
  - o_frame_start is 0 on any clock other than the one that presents (0,0). It is never held.
- o_frame_cnt wraps from 0xFFFF to 0x0000 without any flag.
- Reset mid-frame:
  - All outputs return to reset values immediately, asynchronously.
  - After release the block restarts from IDLE, and no partial-frame pulse is issued.
- Parameters are elaboration constants. No runtime reconfiguration.

Optional Feature:
Macro VTG_TEST_PATTERN_EN.
- Defined:
  - Adds outputs o_tp_red, o_tp_green, o_tp_blue, 8 bits each.
  - These are registered and aligned with o_x/o_y.
  - They show 8 vertical colour bars of width H_ACTIVE/8, with index o_x/(H_ACTIVE/8) clamped to 7. Index order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - All three outputs are 0 when o_de=0 and in reset.
- Not defined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset held, then released with i_en=0 for 5 clocks, then i_en=1 -> outputs stay at reset values until the first i_en clock; that clock shows o_x=0, o_y=0, o_de=1, o_frame_start=1, o_frame_cnt=0.
- i_en=1 continuously through one line -> o_de=1 for x=0..799 and 0 at x=800; o_h_sync=1 exactly for x=840..967; o_x wraps 1055->0 as o_y goes 0->1.
- Run 2 full frames -> o_v_sync high for y=601..604 (4 lines, 4224 clocks); exactly one rising edge per frame; o_frame_start pulses at each (0,0); o_frame_cnt goes 0->1->2; (627,1055) is followed by (0,0).
- i_en toggled 1/0 each clock (pixel tick at half rate) -> outputs hold on i_en=0 clocks; line period is 2112 clocks; o_frame_start stays a single-clock pulse.
- Assert i_rst_n=0 asynchronously at (300,450) mid-clock -> outputs are at reset values before the next clock edge; after release, the next frame restarts at (0,0) with o_frame_cnt=0.
- With VTG_TEST_PATTERN_EN defined, sample at x=250, y=10 -> RGB 00FFFF; at x=799 -> 000000; at x=820 -> 000000 with o_de=0.
